// File: rtl/mem_bus_monitor.sv
// mem_bus_monitor: captures core<->memory accesses that hit an MMIO window into a show-ahead
// trace FIFO and raises sticky halt/timeout flags. Define TRACE_TIMESTAMP_EN to timestamp entries.
module mem_bus_monitor #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       DEPTH     = 16,
    parameter logic [ADDR_W-1:0] WIN_BASE  = ADDR_W'(32'h0000_0800),
    parameter logic [ADDR_W-1:0] WIN_MASK  = ADDR_W'(32'h0000_0800),
    parameter logic [ADDR_W-1:0] HALT_ADDR = ADDR_W'(32'h0000_0FFC),
    parameter int unsigned       TIMEOUT   = 4000,
    parameter int unsigned       CNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic              we,
    output logic              trc_valid,
    input  logic              trc_ready,
    output logic              trc_we,
    output logic [ADDR_W-1:0] trc_addr,
    output logic [DATA_W-1:0] trc_data,
    output logic              halted,
    output logic              timed_out,
    output logic              done,
    output logic [15:0]       drop_cnt,
    output logic [CNT_W-1:0]  cycle_cnt
`ifdef TRACE_TIMESTAMP_EN
    ,
    output logic [CNT_W-1:0]  trc_time
`endif
);

    localparam int unsigned      PTR_W        = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT   = (PTR_W + 1)'(DEPTH);
    localparam bit               TIMEOUT_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE      = PTR_W'(1);
    localparam logic [PTR_W:0]   COUNT_ONE    = (PTR_W + 1)'(1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mem_bus_monitor: DEPTH must be a power of two and at least 2");
    end

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALT,
        ST_TIMEOUT
    } state_t;

    state_t state;

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count;

    logic              mem_we   [DEPTH];
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
`ifdef TRACE_TIMESTAMP_EN
    logic [CNT_W-1:0]  mem_time [DEPTH];
`endif

    logic running;
    logic halt_hit;
    logic budget_hit;
    logic win_hit;
    logic push_req;
    logic fifo_full;
    logic pop;
    logic push;
    logic drop;

    // The halt access wins over everything else in its cycle and is never captured.
    assign running    = (state == ST_RUN);
    assign halt_hit   = running && (address == HALT_ADDR);
    assign budget_hit = running && TIMEOUT_EN && !halt_hit && (cycle_cnt == TIMEOUT_LAST);
    assign win_hit    = ((address & WIN_MASK) == (WIN_BASE & WIN_MASK));
    assign push_req   = running && !halt_hit && win_hit;

    assign trc_valid  = (count != '0);
    assign fifo_full  = (count == FULL_COUNT);
    assign pop        = trc_valid && trc_ready;
    assign push       = push_req && (!fifo_full || pop);
    assign drop       = push_req && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            halted    <= 1'b0;
            timed_out <= 1'b0;
            done      <= 1'b0;
            cycle_cnt <= '0;
        end else if (running) begin
            cycle_cnt <= cycle_cnt + CNT_ONE;
            if (halt_hit) begin
                state  <= ST_HALT;
                halted <= 1'b1;
                done   <= 1'b1;
            end else if (budget_hit) begin
                state     <= ST_TIMEOUT;
                timed_out <= 1'b1;
                done      <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // Entry storage carries no reset; the pointers alone decide what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_we[wr_ptr]   <= we;
            mem_addr[wr_ptr] <= address;
            mem_data[wr_ptr] <= we ? wdata : rdata;
`ifdef TRACE_TIMESTAMP_EN
            mem_time[wr_ptr] <= cycle_cnt;
`endif
        end
    end

    assign trc_we   = trc_valid && mem_we[rd_ptr];
    assign trc_addr = trc_valid ? mem_addr[rd_ptr] : '0;
    assign trc_data = trc_valid ? mem_data[rd_ptr] : '0;
`ifdef TRACE_TIMESTAMP_EN
    assign trc_time = trc_valid ? mem_time[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_mem_bus_monitor.sv
// tb_mem_bus_monitor: randomized bus traffic against a queue-based reference model,
// with a second instance built with a short cycle budget.
module tb_mem_bus_monitor;

    localparam int          DEPTH    = 16;
    localparam int          LONG_TO  = 4000;
    localparam int          SHORT_TO = 10;
    localparam logic [31:0] HALT     = 32'h0000_0FFC;
    localparam logic [31:0] WBASE    = 32'h0000_0800;
    localparam logic [31:0] WMASK    = 32'h0000_0800;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        we;
    logic        trc_ready;

    logic        trc_valid, trc_we, halted, timed_out, done;
    logic [31:0] trc_addr, trc_data, cycle_cnt;
    logic [15:0] drop_cnt;

    logic        t_valid, t_we, t_halted, t_timed_out, t_done;
    logic [31:0] t_addr, t_data, t_cycle_cnt;
    logic [15:0] t_drop_cnt;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] trc_time, t_time;
`endif

    always #5 clk = ~clk;

    mem_bus_monitor dut (
        .clk(clk), .reset(reset), .address(address), .wdata(wdata), .rdata(rdata), .we(we),
        .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_we(trc_we), .trc_addr(trc_addr),
        .trc_data(trc_data), .halted(halted), .timed_out(timed_out), .done(done),
        .drop_cnt(drop_cnt), .cycle_cnt(cycle_cnt)
`ifdef TRACE_TIMESTAMP_EN
        , .trc_time(trc_time)
`endif
    );

    mem_bus_monitor #(.TIMEOUT(SHORT_TO)) dut_to (
        .clk(clk), .reset(reset), .address(address), .wdata(wdata), .rdata(rdata), .we(we),
        .trc_valid(t_valid), .trc_ready(1'b1), .trc_we(t_we), .trc_addr(t_addr),
        .trc_data(t_data), .halted(t_halted), .timed_out(t_timed_out), .done(t_done),
        .drop_cnt(t_drop_cnt), .cycle_cnt(t_cycle_cnt)
`ifdef TRACE_TIMESTAMP_EN
        , .trc_time(t_time)
`endif
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] ts;
    } entry_t;

    entry_t      q[$];
    bit          m_halted, m_to;
    int unsigned m_cnt, m_drop;

    // The short-budget instance always has trc_ready high, so it holds at most the latest capture.
    bit          s_halted, s_to, s_valid;
    int unsigned s_cnt;
    entry_t      s_entry;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic bit inWindow(input logic [31:0] a);
        return (a & WMASK) == (WBASE & WMASK);
    endfunction

    function automatic logic [31:0] randAddr(input bit hit);
        logic [31:0] a;
        a = $urandom & 32'hFFFF_FFFC;
        a = hit ? (a | WBASE) : (a & ~WMASK);
        if (a == HALT) a = 32'h0000_0804;
        return a;
    endfunction

    task automatic modelEdge();
        entry_t e;
        bit     hit;
        if (reset) begin
            q.delete();
            m_halted = 0; m_to = 0; m_cnt = 0; m_drop = 0;
            s_halted = 0; s_to = 0; s_cnt = 0; s_valid = 0;
            return;
        end
        hit    = inWindow(address);
        e.we   = we;
        e.addr = address;
        e.data = we ? wdata : rdata;

        if (q.size() != 0 && trc_ready) void'(q.pop_front());
        if (!m_halted && !m_to) begin
            if (address == HALT) m_halted = 1;
            else begin
                if (m_cnt == LONG_TO - 1) m_to = 1;
                if (hit) begin
                    e.ts = m_cnt;
                    if (q.size() < DEPTH) q.push_back(e);
                    else if (m_drop < 65535) m_drop++;
                end
            end
            m_cnt++;
        end

        s_valid = 0;
        if (!s_halted && !s_to) begin
            if (address == HALT) s_halted = 1;
            else begin
                if (s_cnt == SHORT_TO - 1) s_to = 1;
                if (hit) begin
                    s_valid = 1;
                    s_entry = e;
                    s_entry.ts = s_cnt;
                end
            end
            s_cnt++;
        end
    endtask

    task automatic checkAll();
        checkOutput("trc_valid", 64'(trc_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            checkOutput("trc_we", 64'(trc_we), 64'(q[0].we));
            checkOutput("trc_addr", 64'(trc_addr), 64'(q[0].addr));
            checkOutput("trc_data", 64'(trc_data), 64'(q[0].data));
`ifdef TRACE_TIMESTAMP_EN
            checkOutput("trc_time", 64'(trc_time), 64'(q[0].ts));
`endif
        end
        checkOutput("halted", 64'(halted), 64'(m_halted));
        checkOutput("timed_out", 64'(timed_out), 64'(m_to));
        checkOutput("done", 64'(done), 64'(m_halted | m_to));
        checkOutput("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        checkOutput("cycle_cnt", 64'(cycle_cnt), 64'(m_cnt));

        checkOutput("s_valid", 64'(t_valid), 64'(s_valid));
        if (s_valid) begin
            checkOutput("s_we", 64'(t_we), 64'(s_entry.we));
            checkOutput("s_addr", 64'(t_addr), 64'(s_entry.addr));
            checkOutput("s_data", 64'(t_data), 64'(s_entry.data));
`ifdef TRACE_TIMESTAMP_EN
            checkOutput("s_time", 64'(t_time), 64'(s_entry.ts));
`endif
        end
        checkOutput("s_halted", 64'(t_halted), 64'(s_halted));
        checkOutput("s_timed_out", 64'(t_timed_out), 64'(s_to));
        checkOutput("s_done", 64'(t_done), 64'(s_halted | s_to));
        checkOutput("s_drop_cnt", 64'(t_drop_cnt), 64'd0);
        checkOutput("s_cycle_cnt", 64'(t_cycle_cnt), 64'(s_cnt));
    endtask

    task automatic applyStimulus(input logic rst, input logic [31:0] a, input logic w,
                                 input logic [31:0] wd, input logic [31:0] rd, input logic rdy);
        @(negedge clk);
        reset = rst; address = a; we = w; wdata = wd; rdata = rd; trc_ready = rdy;
        @(posedge clk);
        modelEdge();
        #1;
        checkAll();
    endtask

    task automatic randomCycle(input int hit_pct, input int rdy_pct);
        logic [31:0] a;
        logic        w, r;
        a = randAddr(int'($urandom_range(0, 99)) < hit_pct);
        w = 1'($urandom_range(0, 1));
        r = int'($urandom_range(0, 99)) < rdy_pct;
        applyStimulus(1'b0, a, w, $urandom, $urandom, r);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; address = '0; we = 1'b0; wdata = '0; rdata = '0; trc_ready = 1'b0;

        repeat (3) applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("reset_valid", 64'(trc_valid), 64'd0);
        applyStimulus(1'b0, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("first_run_cnt", 64'(cycle_cnt), 64'd1);

        for (int i = 0; i < 9; i++) applyStimulus(1'b0, randAddr(1'b0), 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b1);
        checkOutput("short_timeout_flag", 64'(t_timed_out), 64'd1);
        checkOutput("short_timeout_cnt", 64'(t_cycle_cnt), 64'd10);

        applyStimulus(1'b0, 32'h804, 1'b1, 32'hDEAD_BEEF, $urandom, 1'b1);
        checkOutput("wr_valid", 64'(trc_valid), 64'd1);
        checkOutput("wr_we", 64'(trc_we), 64'd1);
        checkOutput("wr_addr", 64'(trc_addr), 64'h804);
        checkOutput("wr_data", 64'(trc_data), 64'hDEAD_BEEF);
        applyStimulus(1'b0, 32'h808, 1'b0, $urandom, 32'h1234_5678, 1'b1);
        checkOutput("rd_we", 64'(trc_we), 64'd0);
        checkOutput("rd_addr", 64'(trc_addr), 64'h808);
        checkOutput("rd_data", 64'(trc_data), 64'h1234_5678);
        applyStimulus(1'b0, 32'h100, 1'b0, 32'h0, 32'h0, 1'b1);

        for (int i = 0; i < 18; i++)
            applyStimulus(1'b0, 32'h800 + 32'(4 * i), 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0);
        checkOutput("full_drop_cnt", 64'(drop_cnt), 64'd2);
        checkOutput("full_head_addr", 64'(trc_addr), 64'h800);
        applyStimulus(1'b0, 32'h804, 1'b1, 32'hCAFE_0001, 32'h0, 1'b1);
        checkOutput("full_pushpop_drop", 64'(drop_cnt), 64'd2);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 32'h100, 1'b0, 32'h0, 32'h0, 1'b1);
        checkOutput("drained_valid", 64'(trc_valid), 64'd0);

        applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 49; i++) randomCycle(70, 50);
        applyStimulus(1'b0, HALT, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
        checkOutput("halt_flag", 64'(halted), 64'd1);
        checkOutput("halt_done", 64'(done), 64'd1);
        checkOutput("halt_cnt", 64'(cycle_cnt), 64'd50);
        for (int i = 0; i < 10; i++) randomCycle(100, 30);
        for (int i = 0; i < 20; i++) randomCycle(100, 100);
        checkOutput("halt_drained", 64'(trc_valid), 64'd0);
        checkOutput("halt_cnt_frozen", 64'(cycle_cnt), 64'd50);

        applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, randAddr(1'b0), 1'b0, $urandom, $urandom, 1'b1);
        applyStimulus(1'b0, HALT, 1'b0, $urandom, $urandom, 1'b1);
        checkOutput("short_halt_flag", 64'(t_halted), 64'd1);
        checkOutput("short_halt_no_to", 64'(t_timed_out), 64'd0);
        checkOutput("short_halt_cnt", 64'(t_cycle_cnt), 64'd10);

        applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 19; i++) applyStimulus(1'b0, randAddr(1'b1), 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0);
        for (int i = 0; i < 11; i++) applyStimulus(1'b0, randAddr(1'b0), 1'b0, $urandom, $urandom, 1'b1);
        checkOutput("pre_reset_drop", 64'(drop_cnt), 64'd3);
        checkOutput("pre_reset_valid", 64'(trc_valid), 64'd1);
        applyStimulus(1'b1, randAddr(1'b1), 1'b1, $urandom, $urandom, 1'b0);
        checkOutput("mid_reset_valid", 64'(trc_valid), 64'd0);
        checkOutput("mid_reset_drop", 64'(drop_cnt), 64'd0);
`ifdef TRACE_TIMESTAMP_EN
        checkOutput("mid_reset_time", 64'(trc_time), 64'd0);
`endif
        applyStimulus(1'b0, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("post_reset_cnt", 64'(cycle_cnt), 64'd1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0)
                applyStimulus(1'b1, randAddr(1'b1), 1'b0, $urandom, $urandom, 1'b1);
            else if ($urandom_range(0, 149) == 0)
                applyStimulus(1'b0, HALT, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
            else
                randomCycle(60, (i / 50) % 2 == 0 ? 30 : 80);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
